// File: rtl/jk_cmd_driver.sv
`default_nettype none
// =============================================================================
// jk_cmd_driver - FIFO-buffered set/clear/toggle/hold player for a JK flop,
// with optional Q checker (JK_CMD_DRIVER_CHECK_EN).   Revision: 1.0
// =============================================================================
module jk_cmd_driver #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [LEN_W-1:0]           cmd_len,
  output logic                       J,
  output logic                       K,
  input  logic                       q_in,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       mismatch,
  output logic [CNT_W-1:0]           err_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int ENT_W = LEN_W + 2;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_DRIVE = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [ENT_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [LEN_W-1:0]   remain, remain_nxt;
  logic               j_nxt, k_nxt;
  logic               push, pop;
  logic [1:0]         head_op;
  logic [LEN_W-1:0]   head_len;
  logic               have_cmd;

  assign cmd_ready = (level < LVL_W'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign have_cmd  = (level != '0);
  assign head_op   = mem[rd_ptr][ENT_W-1:LEN_W];
  assign head_len  = mem[rd_ptr][LEN_W-1:0];
  assign busy      = (state == S_DRIVE) || have_cmd;

  // Storage carries no reset; only the pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_op, cmd_len};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        level <= level + LVL_W'(1);
      end else if (pop && !push) begin
        level <= level - LVL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      J      <= 1'b0;
      K      <= 1'b0;
      remain <= '0;
    end else begin
      state  <= state_nxt;
      J      <= j_nxt;
      K      <= k_nxt;
      remain <= remain_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    j_nxt      = J;
    k_nxt      = K;
    remain_nxt = remain;
    pop        = 1'b0;
    case (state)
      S_IDLE: begin
        j_nxt = 1'b0;
        k_nxt = 1'b0;
        if (have_cmd) begin
          pop            = 1'b1;
          {j_nxt, k_nxt} = head_op;
          remain_nxt     = head_len;
          state_nxt      = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (remain != '0) begin
          remain_nxt = remain - LEN_W'(1);
        end else if (have_cmd) begin
          // Chain straight into the next command with no gap cycle.
          pop            = 1'b1;
          {j_nxt, k_nxt} = head_op;
          remain_nxt     = head_len;
        end else begin
          j_nxt     = 1'b0;
          k_nxt     = 1'b0;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        j_nxt     = 1'b0;
        k_nxt     = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

`ifdef JK_CMD_DRIVER_CHECK_EN
  logic exp_q;

  // exp is compared with the flop's Q before it advances from this cycle's J/K.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q    <= 1'b0;
      mismatch <= 1'b0;
      err_cnt  <= '0;
    end else begin
      if (q_in != exp_q) begin
        mismatch <= 1'b1;
        if (err_cnt != '1) begin
          err_cnt <= err_cnt + CNT_W'(1);
        end
      end
      case ({J, K})
        2'b01:   exp_q <= 1'b0;
        2'b10:   exp_q <= 1'b1;
        2'b11:   exp_q <= ~exp_q;
        default: exp_q <= exp_q;
      endcase
    end
  end
`else
  logic unused_q_in;
  assign unused_q_in = q_in;
  assign mismatch    = 1'b0;
  assign err_cnt     = '0;
`endif

endmodule
`default_nettype wire
